// File: rtl/execute_stage_if.sv
// execute_stage_if -- operation/result bundle for the execute stage.
//
// Issue side : InValid/InReady handshake carrying OpCode, A, B, Dest.
// Result side: OutValid/OutReady handshake carrying Result, ResultDest,
//              plus the Flags status register and the Busy indication.
//
// Modports:
//   master -- the issuing/writeback side (drives operations, consumes results)
//   slave  -- the execute stage itself
interface execute_stage_if;
  logic        InValid;
  logic        InReady;
  logic [3:0]  OpCode;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  Dest;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] Result;
  logic [3:0]  ResultDest;
  logic [4:0]  Flags;
  logic        Busy;

  modport master (
    output InValid, OpCode, A, B, Dest, OutReady,
    input  InReady, OutValid, Result, ResultDest, Flags, Busy
  );

  modport slave (
    input  InValid, OpCode, A, B, Dest, OutReady,
    output InReady, OutValid, Result, ResultDest, Flags, Busy
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage -- single-issue ALU stage with a one-entry result register
// and an optional iterative 16x16 shift-add multiplier.
//
// Ports:
//   Clock  in   system clock
//   Reset  in   asynchronous, active-low reset
//   exIf   slave modport of execute_stage_if:
//            InValid/InReady, OpCode[3:0], A[15:0], B[15:0], Dest[3:0]  (issue)
//            OutValid/OutReady, Result[15:0], ResultDest[3:0]           (result)
//            Flags[4:0] = {C,L,F,Z,N}, Busy                             (status)
//
// Configuration:
//   EXECUTE_STAGE_MUL_EN  defined   -> opcode 4'hB is an iterative multiply
//                         undefined -> opcode 4'hB is a NOP, Busy tied low
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | no result held, ready for any operation
// FULL  | result held in Result/ResultDest, OutValid=1
// MUL   | multiply iterating, no input accepted, Busy=1
module execute_stage (
  input  logic           Clock,
  input  logic           Reset,
  execute_stage_if.slave exIf
);

  localparam int FlagC = 4;
  localparam int FlagL = 3;
  localparam int FlagF = 2;
  localparam int FlagZ = 1;
  localparam int FlagN = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    MUL   = 2'd2
  } stateT;

  stateT       state;
  stateT       stateNext;

  logic        accept;
  logic        isWrite;
  logic        isMul;
  logic [15:0] aluResult;
  logic [4:0]  flagsNext;
  logic        setZn;
  logic [16:0] sum;
  logic [16:0] diff;

  logic [15:0] resultQ;
  logic [3:0]  resultDestQ;
  logic [4:0]  flagsQ;

  logic        mulDone;
  logic [15:0] mulProduct;

  assign accept = exIf.InValid && exIf.InReady;

  // Opcode classification: isWrite ops land in the result register on the
  // accept edge; CMP, NOP (and MUL when not built) never touch it.
  always_comb begin
    isWrite = 1'b0;
    isMul   = 1'b0;
    case (exIf.OpCode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'h7, 4'h8, 4'hA: isWrite = 1'b1;
`ifdef EXECUTE_STAGE_MUL_EN
      4'hB:                         isMul   = 1'b1;
`endif
      default: ;
    endcase
  end

  // Single-cycle datapath and next flag value for the offered operation.
  always_comb begin
    sum       = {1'b0, exIf.A} + {1'b0, exIf.B};
    diff      = {1'b0, exIf.A} - {1'b0, exIf.B};
    aluResult = resultQ;
    flagsNext = flagsQ;
    setZn     = 1'b0;
    case (exIf.OpCode)
      4'h0: begin
        aluResult        = sum[15:0];
        flagsNext[FlagC] = sum[16];
        flagsNext[FlagF] = (exIf.A[15] == exIf.B[15]) && (sum[15] != exIf.A[15]);
        setZn            = 1'b1;
      end
      4'h1: begin
        aluResult        = diff[15:0];
        flagsNext[FlagC] = diff[16];
        flagsNext[FlagF] = (exIf.A[15] != exIf.B[15]) && (diff[15] != exIf.A[15]);
        setZn            = 1'b1;
      end
      4'h2: begin aluResult = exIf.A & exIf.B; setZn = 1'b1; end
      4'h3: begin aluResult = exIf.A | exIf.B; setZn = 1'b1; end
      4'h4: begin aluResult = exIf.A ^ exIf.B; setZn = 1'b1; end
      4'h5: begin aluResult = ~exIf.A;         setZn = 1'b1; end
      4'h6: begin aluResult = exIf.A << exIf.B[3:0]; setZn = 1'b1; end
      4'h7: begin aluResult = exIf.A >> exIf.B[3:0]; setZn = 1'b1; end
      4'h8: begin
        aluResult = $signed(exIf.A) >>> exIf.B[3:0];
        setZn     = 1'b1;
      end
      4'h9: begin
        // Borrow bit of A-B doubles as the unsigned less-than.
        flagsNext[FlagL] = diff[16];
        flagsNext[FlagN] = $signed(exIf.A) < $signed(exIf.B);
        flagsNext[FlagZ] = (exIf.A == exIf.B);
      end
      4'hA: aluResult = exIf.B;
      default: ;
    endcase
    if (setZn) begin
      flagsNext[FlagZ] = (aluResult == 16'h0000);
      flagsNext[FlagN] = aluResult[15];
    end
  end

`ifdef EXECUTE_STAGE_MUL_EN
  logic [4:0]  mulCount;
  logic [15:0] mulCand;
  logic [15:0] mulPlier;
  logic [15:0] mulAcc;
  logic [15:0] mulAccStep;

  assign mulAccStep = mulAcc + (mulPlier[0] ? mulCand : 16'h0000);
  assign mulProduct = mulAccStep;
  // Last of the 16 iterations lands the product directly in the result register.
  assign mulDone    = (state == MUL) && (mulCount == 5'd1);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mulCount <= 5'd0;
      mulCand  <= 16'h0000;
      mulPlier <= 16'h0000;
      mulAcc   <= 16'h0000;
    end else if (accept && isMul) begin
      mulCount <= 5'd16;
      mulCand  <= exIf.A;
      mulPlier <= exIf.B;
      mulAcc   <= 16'h0000;
    end else if (state == MUL) begin
      mulCount <= mulCount - 5'd1;
      mulCand  <= mulCand << 1;
      mulPlier <= mulPlier >> 1;
      mulAcc   <= mulAccStep;
    end
  end
`else
  assign mulDone    = 1'b0;
  assign mulProduct = 16'h0000;
`endif

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= EMPTY;
    else        state <= stateNext;
  end

  // Next-state logic. An accept in FULL implies OutReady=1, so the held
  // result is always retired when a new operation is taken.
  always_comb begin
    stateNext = state;
    case (state)
      EMPTY: begin
        if (accept && isMul)        stateNext = MUL;
        else if (accept && isWrite) stateNext = FULL;
      end
      FULL: begin
        if (accept && isMul)        stateNext = MUL;
        else if (accept && isWrite) stateNext = FULL;
        else if (exIf.OutReady)     stateNext = EMPTY;
      end
      MUL: begin
        if (mulDone)                stateNext = FULL;
      end
      default:                      stateNext = EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    exIf.InReady  = (state == EMPTY) || ((state == FULL) && exIf.OutReady);
    exIf.OutValid = (state == FULL);
`ifdef EXECUTE_STAGE_MUL_EN
    exIf.Busy     = (state == MUL);
`else
    exIf.Busy     = 1'b0;
`endif
  end

  // Result and flag registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      resultQ     <= 16'h0000;
      resultDestQ <= 4'h0;
      flagsQ      <= 5'b00000;
    end else begin
      if (accept) begin
        flagsQ <= flagsNext;
        if (isWrite) begin
          resultQ     <= aluResult;
          resultDestQ <= exIf.Dest;
        end
        // OutValid is low throughout MUL, so the destination can be parked early.
        if (isMul) resultDestQ <= exIf.Dest;
      end
      if (mulDone) begin
        resultQ       <= mulProduct;
        flagsQ[FlagZ] <= (mulProduct == 16'h0000);
        flagsQ[FlagN] <= mulProduct[15];
      end
    end
  end

  assign exIf.Result     = resultQ;
  assign exIf.ResultDest = resultDestQ;
  assign exIf.Flags      = flagsQ;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage -- directed self-checking bench for execute_stage.
// Drives inputs 1ns after the rising edge and samples outputs there as well.
// Flags are {C,L,F,Z,N}. Multiply scenarios follow EXECUTE_STAGE_MUL_EN.
module tb_execute_stage;
  logic Clock;
  logic Reset;
  int   compared;
  int   mismatched;

  execute_stage_if exIf();

  execute_stage dut (
    .Clock (Clock),
    .Reset (Reset),
    .exIf  (exIf.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic offer(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] d);
    exIf.InValid = 1'b1;
    exIf.OpCode  = op;
    exIf.A       = a;
    exIf.B       = b;
    exIf.Dest    = d;
  endtask

  task automatic drain();
    exIf.InValid  = 1'b0;
    exIf.OutReady = 1'b1;
    tick();
    exIf.OutReady = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    exIf.InValid = 1'b0; exIf.OpCode = 4'h0; exIf.A = 16'h0; exIf.B = 16'h0;
    exIf.Dest = 4'h0; exIf.OutReady = 1'b0;
    #12;
    compared++;
    if (exIf.OutValid !== 1'b0 || exIf.Busy !== 1'b0 || exIf.InReady !== 1'b1) begin
      $display("FAIL reset_ctrl: OutValid=%b Busy=%b InReady=%b, want 0 0 1",
               exIf.OutValid, exIf.Busy, exIf.InReady);
      mismatched++;
    end
    compared++;
    if (exIf.Result !== 16'h0000 || exIf.ResultDest !== 4'h0 || exIf.Flags !== 5'b00000) begin
      $display("FAIL reset_data: Result=%h Dest=%h Flags=%b, want 0000 0 00000",
               exIf.Result, exIf.ResultDest, exIf.Flags);
      mismatched++;
    end
    @(negedge Clock);
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_add_overflow();
    offer(4'h0, 16'h7FFF, 16'h0001, 4'h3);
    tick();
    exIf.InValid = 1'b0;
    compared++;
    if (exIf.OutValid !== 1'b1 || exIf.Result !== 16'h8000 || exIf.ResultDest !== 4'h3) begin
      $display("FAIL add_ovf_result: OutValid=%b Result=%h Dest=%h, want 1 8000 3",
               exIf.OutValid, exIf.Result, exIf.ResultDest);
      mismatched++;
    end
    compared++;
    if (exIf.Flags !== 5'b00101) begin
      $display("FAIL add_ovf_flags: got %b want 00101", exIf.Flags);
      mismatched++;
    end
    compared++;
    if (exIf.InReady !== 1'b0) begin
      $display("FAIL add_ovf_inready: got %b want 0", exIf.InReady);
      mismatched++;
    end
    drain();
    compared++;
    if (exIf.OutValid !== 1'b0) begin
      $display("FAIL add_ovf_drain: OutValid=%b want 0", exIf.OutValid);
      mismatched++;
    end
  endtask

  task automatic test_back_to_back();
    offer(4'h0, 16'h0001, 16'h0002, 4'h1);
    tick();
    exIf.InValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (exIf.InReady !== 1'b0 || exIf.OutValid !== 1'b1 || exIf.Result !== 16'h0003) begin
        $display("FAIL hold_%0d: InReady=%b OutValid=%b Result=%h, want 0 1 0003",
                 i, exIf.InReady, exIf.OutValid, exIf.Result);
        mismatched++;
      end
      tick();
    end
    exIf.OutReady = 1'b1;
    offer(4'h1, 16'h0005, 16'h0005, 4'h2);
    #1;
    compared++;
    if (exIf.InReady !== 1'b1) begin
      $display("FAIL b2b_inready: got %b want 1", exIf.InReady);
      mismatched++;
    end
    tick();
    exIf.InValid  = 1'b0;
    exIf.OutReady = 1'b0;
    compared++;
    if (exIf.OutValid !== 1'b1 || exIf.Result !== 16'h0000 || exIf.ResultDest !== 4'h2 ||
        exIf.Flags !== 5'b00010) begin
      $display("FAIL b2b_sub: OutValid=%b Result=%h Dest=%h Flags=%b, want 1 0000 2 00010",
               exIf.OutValid, exIf.Result, exIf.ResultDest, exIf.Flags);
      mismatched++;
    end
    drain();
  endtask

  task automatic test_cmp();
    exIf.OutReady = 1'b1;
    offer(4'h0, 16'hFFFF, 16'h0002, 4'h4);
    tick();
    compared++;
    if (exIf.Result !== 16'h0001 || exIf.Flags !== 5'b10000) begin
      $display("FAIL cmp_setup: Result=%h Flags=%b, want 0001 10000", exIf.Result, exIf.Flags);
      mismatched++;
    end
    offer(4'h9, 16'hFFFF, 16'h0001, 4'h7);
    tick();
    compared++;
    if (exIf.Flags !== 5'b10001 || exIf.OutValid !== 1'b0 || exIf.Result !== 16'h0001) begin
      $display("FAIL cmp_neg: Flags=%b OutValid=%b Result=%h, want 10001 0 0001",
               exIf.Flags, exIf.OutValid, exIf.Result);
      mismatched++;
    end
    offer(4'h9, 16'h0001, 16'h0002, 4'h7);
    tick();
    exIf.InValid  = 1'b0;
    exIf.OutReady = 1'b0;
    compared++;
    if (exIf.Flags !== 5'b11001 || exIf.OutValid !== 1'b0) begin
      $display("FAIL cmp_less: Flags=%b OutValid=%b, want 11001 0", exIf.Flags, exIf.OutValid);
      mismatched++;
    end
  endtask

  task automatic test_shifts();
    logic [3:0]  ops [3];
    logic [15:0] exp [3];
    ops[0] = 4'h6; exp[0] = 16'h0002;
    ops[1] = 4'h7; exp[1] = 16'h4000;
    ops[2] = 4'h8; exp[2] = 16'hC000;
    exIf.OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(ops[i], 16'h8001, 16'hFFF1, 4'h6);
      tick();
      compared++;
      if (exIf.OutValid !== 1'b1 || exIf.Result !== exp[i]) begin
        $display("FAIL shift_op%h: OutValid=%b Result=%h, want 1 %h",
                 ops[i], exIf.OutValid, exIf.Result, exp[i]);
        mismatched++;
      end
    end
    compared++;
    if (exIf.Flags !== 5'b11001) begin
      $display("FAIL shift_flags: got %b want 11001", exIf.Flags);
      mismatched++;
    end
    drain();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        expValid;
    logic [15:0] expResult;
    logic [4:0]  expFlags;
  } vecT;

  task automatic test_alu_table();
    vecT v [8];
    v[0] = '{4'h2, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 5'b11000};
    v[1] = '{4'h3, 16'hF000, 16'h000F, 1'b1, 16'hF00F, 5'b11001};
    v[2] = '{4'h4, 16'hAAAA, 16'hAAAA, 1'b1, 16'h0000, 5'b11010};
    v[3] = '{4'h5, 16'h00FF, 16'h1234, 1'b1, 16'hFF00, 5'b11001};
    v[4] = '{4'hA, 16'h0000, 16'h1234, 1'b1, 16'h1234, 5'b11001};
    v[5] = '{4'h1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 5'b01100};
    v[6] = '{4'h0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 5'b11010};
    v[7] = '{4'hC, 16'h5555, 16'h5555, 1'b0, 16'h0000, 5'b11010};
    for (int i = 0; i < 8; i++) begin
      offer(v[i].op, v[i].a, v[i].b, 4'h9);
      tick();
      exIf.InValid = 1'b0;
      compared++;
      if (exIf.OutValid !== v[i].expValid || exIf.Result !== v[i].expResult ||
          exIf.Flags !== v[i].expFlags) begin
        $display("FAIL alu_op%h: OutValid=%b Result=%h Flags=%b, want %b %h %b",
                 v[i].op, exIf.OutValid, exIf.Result, exIf.Flags,
                 v[i].expValid, v[i].expResult, v[i].expFlags);
        mismatched++;
      end
      drain();
    end
  endtask

`ifdef EXECUTE_STAGE_MUL_EN
  task automatic test_mul();
    int bad;
    offer(4'hB, 16'h0123, 16'h0010, 4'h5);
    tick();
    exIf.InValid = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (exIf.Busy !== 1'b1 || exIf.OutValid !== 1'b0 || exIf.InReady !== 1'b0) bad++;
      tick();
    end
    if (exIf.Busy !== 1'b1) bad++;
    compared++;
    if (bad != 0) begin
      $display("FAIL mul_busy: %0d bad cycles, want 0", bad);
      mismatched++;
    end
    tick();
    compared++;
    if (exIf.Busy !== 1'b0 || exIf.OutValid !== 1'b1 || exIf.Result !== 16'h1230 ||
        exIf.ResultDest !== 4'h5 || exIf.Flags !== 5'b11000) begin
      $display("FAIL mul_result: Busy=%b OutValid=%b Result=%h Dest=%h Flags=%b, want 0 1 1230 5 11000",
               exIf.Busy, exIf.OutValid, exIf.Result, exIf.ResultDest, exIf.Flags);
      mismatched++;
    end
    offer(4'hB, 16'h0002, 16'h0003, 4'h8);
    #1;
    compared++;
    if (exIf.InReady !== 1'b0) begin
      $display("FAIL mul_full_block: InReady=%b want 0", exIf.InReady);
      mismatched++;
    end
    exIf.OutReady = 1'b1;
    tick();
    exIf.InValid  = 1'b0;
    exIf.OutReady = 1'b0;
    compared++;
    if (exIf.Busy !== 1'b1 || exIf.OutValid !== 1'b0) begin
      $display("FAIL mul_from_full: Busy=%b OutValid=%b, want 1 0", exIf.Busy, exIf.OutValid);
      mismatched++;
    end
    for (int i = 0; i < 16; i++) tick();
    compared++;
    if (exIf.OutValid !== 1'b1 || exIf.Result !== 16'h0006 || exIf.ResultDest !== 4'h8) begin
      $display("FAIL mul_small: OutValid=%b Result=%h Dest=%h, want 1 0006 8",
               exIf.OutValid, exIf.Result, exIf.ResultDest);
      mismatched++;
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    offer(4'hB, 16'h0003, 16'h0005, 4'h2);
    tick();
    exIf.InValid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    Reset = 1'b0;
    #2;
    compared++;
    if (exIf.OutValid !== 1'b0 || exIf.Busy !== 1'b0 || exIf.Flags !== 5'b00000 ||
        exIf.Result !== 16'h0000) begin
      $display("FAIL rst_mul_now: OutValid=%b Busy=%b Flags=%b Result=%h, want 0 0 00000 0000",
               exIf.OutValid, exIf.Busy, exIf.Flags, exIf.Result);
      mismatched++;
    end
    @(negedge Clock);
    Reset = 1'b1;
    tick();
    compared++;
    if (exIf.InReady !== 1'b1) begin
      $display("FAIL rst_mul_inready: got %b want 1", exIf.InReady);
      mismatched++;
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (exIf.OutValid !== 1'b0 || exIf.Busy !== 1'b0) seen++;
      tick();
    end
    compared++;
    if (seen != 0) begin
      $display("FAIL rst_mul_noresult: %0d cycles with OutValid/Busy, want 0", seen);
      mismatched++;
    end
  endtask
`else
  task automatic test_mul_disabled();
    offer(4'hB, 16'h0123, 16'h0010, 4'h5);
    tick();
    exIf.InValid = 1'b0;
    compared++;
    if (exIf.OutValid !== 1'b0 || exIf.Busy !== 1'b0 || exIf.InReady !== 1'b1 ||
        exIf.Flags !== 5'b11010) begin
      $display("FAIL mul_nop: OutValid=%b Busy=%b InReady=%b Flags=%b, want 0 0 1 11010",
               exIf.OutValid, exIf.Busy, exIf.InReady, exIf.Flags);
      mismatched++;
    end
    tick();
    compared++;
    if (exIf.OutValid !== 1'b0 || exIf.Busy !== 1'b0) begin
      $display("FAIL mul_nop_later: OutValid=%b Busy=%b, want 0 0", exIf.OutValid, exIf.Busy);
      mismatched++;
    end
  endtask
`endif

  task automatic test_reset_full();
    offer(4'h0, 16'h0001, 16'h0001, 4'hC);
    tick();
    exIf.InValid = 1'b0;
    compared++;
    if (exIf.OutValid !== 1'b1 || exIf.Result !== 16'h0002) begin
      $display("FAIL rstfull_setup: OutValid=%b Result=%h, want 1 0002", exIf.OutValid, exIf.Result);
      mismatched++;
    end
    Reset = 1'b0;
    #2;
    compared++;
    if (exIf.OutValid !== 1'b0 || exIf.Result !== 16'h0000 || exIf.ResultDest !== 4'h0 ||
        exIf.Flags !== 5'b00000) begin
      $display("FAIL rstfull_now: OutValid=%b Result=%h Dest=%h Flags=%b, want 0 0000 0 00000",
               exIf.OutValid, exIf.Result, exIf.ResultDest, exIf.Flags);
      mismatched++;
    end
    @(negedge Clock);
    Reset = 1'b1;
    tick();
    compared++;
    if (exIf.InReady !== 1'b1 || exIf.OutValid !== 1'b0) begin
      $display("FAIL rstfull_release: InReady=%b OutValid=%b, want 1 0", exIf.InReady, exIf.OutValid);
      mismatched++;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_cmp();
    test_shifts();
    test_alu_table();
`ifdef EXECUTE_STAGE_MUL_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_mul_disabled();
`endif
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have ports: Clock  in  1  system clock; Reset  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: InValid  in  1  operation offered; InReady  out  1  stage accepts operation this cycle.
REQ-003 SHALL have: OpCode  in  4  operation; A  in  16  register-file port A operand; B  in  16  register-file port B operand; Dest  in  4  destination register index.
REQ-004 SHALL have: OutValid  out  1  result held; OutReady  in  1  writeback consumes result; Result  out  16  result value; ResultDest  out  4  destination index.
REQ-005 SHALL have: Flags  out  5  {C,L,F,Z,N} status register; Busy  out  1  multiply in progress.

Function
REQ-006 SHALL accept an operation on a rising Clock edge where InValid=1 and InReady=1 (accept edge).
REQ-007 SHALL drive InReady = (state EMPTY) or (state FULL and OutReady=1); InReady=0 in state MUL.
REQ-008 SHALL use states EMPTY, FULL, MUL; EMPTY->FULL on accepting a writing op; FULL->EMPTY on OutValid&OutReady with no writing op accepted; FULL->FULL on simultaneous consume and accept (result replaced, no bubble).
REQ-009 SHALL hold OutValid=1 exactly in state FULL; Result/ResultDest stable while OutValid=1 and OutReady=0.
REQ-010 SHALL present a single-cycle op result one cycle after acceptance (OutValid high after the accept edge).
REQ-011 SHALL decode opcodes: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 LSH A<<B[3:0]; 7 RSH logical A>>B[3:0]; 8 ARSH arithmetic A>>>B[3:0]; 9 CMP; A MOV B; B MUL; C-F NOP.
REQ-012 SHALL compute all arithmetic modulo 2^16; shift amount uses B[3:0] only, upper bits of B ignored.
REQ-013 SHALL treat CMP and NOP as non-writing: accepted whenever InReady=1, never enter FULL, leave OutValid unaffected.
REQ-014 SHALL update Flags at the accept edge: ADD/SUB set C (carry out / borrow, i.e. A<B unsigned for SUB), F (signed overflow), Z (result==0), N (result[15]); logic/shift/NOT set Z,N only; CMP sets L (A<B unsigned), N (A<B signed), Z (A==B) and leaves C,F; MOV/NOP leave all flags.
REQ-015 SHALL leave unchanged every flag not listed for an opcode.
REQ-016 SHALL on MUL accept: enter MUL, Busy=1, perform 16 shift-add iterations one per cycle, produce product[15:0], enter FULL 16 cycles after accept edge, set Z,N at that completion edge.
REQ-017 SHALL only accept MUL when OutValid consumption leaves the output register free (MUL accept from FULL requires OutReady=1 same cycle, which retires the held result).

Reset
REQ-018 SHALL on Reset=0 immediately force state EMPTY, OutValid=0, Busy=0, Result=16'h0000, ResultDest=4'h0, Flags=5'b00000, multiply iteration counter 0.
REQ-019 SHALL abort an in-progress MUL on reset with no result produced; InReady=1 on first cycle after release.

Configuration
REQ-020 SHALL compile the multiplier only when macro EXECUTE_STAGE_MUL_EN is defined.
REQ-021 SHALL, with EXECUTE_STAGE_MUL_EN undefined, treat opcode B as NOP, never enter MUL, and tie Busy to 0.

Verification
REQ-022 Reset mid-MUL: accept MUL A=3 B=5, assert Reset=0 at cycle 8 -> OutValid=0, Busy=0, Flags=0 immediately; no result after release.
REQ-023 ADD overflow: A=16'h7FFF B=16'h0001 op 0 -> Result=16'h8000, F=1, N=1, C=0, Z=0 one cycle later.
REQ-024 Back-pressure: ADD accepted, OutReady=0 for 3 cycles -> InReady=0, Result stable; OutReady=1 with next SUB A=5 B=5 -> Result=0, Z=1, C=0 next cycle, no bubble.
REQ-025 CMP: A=16'hFFFF B=16'h0001 op 9 -> L=0, N=1, Z=0, C/F unchanged, OutValid unchanged.
REQ-026 MUL (macro defined): A=16'h0123 B=16'h0010 -> Busy=1 for 16 cycles, then OutValid=1, Result=16'h1230; macro undefined -> treated as NOP, OutValid stays 0.
REQ-027 Shifts: A=16'h8001 B=16'hFFF1 -> LSH 16'h0002, RSH 16'h4000, ARSH 16'hC000.
